// File: rtl/fp_div_arbiter.sv
// Two-port arbiter in front of a shared floating-point divider.
// Grants one port at a time, forwards its operands, and returns the quotient or a timeout.
module fp_div_arbiter #(
    parameter bit          RR  = 1'b1,
    parameter int unsigned TMO = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] x0,
    input  logic [31:0] y0,
    input  logic [31:0] x1,
    input  logic [31:0] y1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] z0,
    output logic [31:0] z1,
    output logic        run,
    output logic [31:0] dx,
    output logic [31:0] dy,
    input  logic        stall,
    input  logic [31:0] dz
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic          gp;
    logic          lp;
    logic [CW-1:0] cnt;
    logic          gnt_c;
    logic          gnt_p_c;

    // Grant decode; ack must flag the cycle in which the operands are sampled.
    always_comb begin
        gnt_c   = 1'b0;
        gnt_p_c = 1'b0;
        ack0    = 1'b0;
        ack1    = 1'b0;
        if (state == IDLE && (req0 || req1)) begin
            gnt_c = 1'b1;
            if (req0 && req1) begin
                gnt_p_c = RR ? ~lp : 1'b0;
            end else begin
                gnt_p_c = req1;
            end
        end
        if (!rst) begin
            ack0 = gnt_c & ~gnt_p_c;
            ack1 = gnt_c &  gnt_p_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gp    <= 1'b0;
            lp    <= 1'b1;
            cnt   <= '0;
            run   <= 1'b0;
            dx    <= '0;
            dy    <= '0;
            z0    <= '0;
            z1    <= '0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_c) begin
                        gp    <= gnt_p_c;
                        lp    <= gnt_p_c;
                        dx    <= gnt_p_c ? x1 : x0;
                        dy    <= gnt_p_c ? y1 : y0;
                        cnt   <= '0;
                        run   <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // A valid quotient wins over a watchdog expiry in the same cycle.
                    if (!stall) begin
                        if (gp) z1 <= dz;
                        else    z0 <= dz;
                        done0 <= ~gp;
                        done1 <=  gp;
                        run   <= 1'b0;
                        state <= DONE;
                    end else if (cnt == CW'(TMO)) begin
                        if (gp) z1 <= W'(0);
                        else    z0 <= W'(0);
                        done0 <= ~gp;
                        done1 <=  gp;
                        err0  <= ~gp;
                        err1  <=  gp;
                        run   <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    run   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters share stimulus, each with a 25-step divider stub.
module tb_fp_div_arbiter;

    localparam int unsigned TMO = 31;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [31:0] x0, y0, x1, y1;
    logic        stuck;

    logic        a_ack0, a_ack1, a_done0, a_done1, a_err0, a_err1, a_run, a_stall;
    logic [31:0] a_z0, a_z1, a_dx, a_dy, a_dz;
    logic        b_ack0, b_ack1, b_done0, b_done1, b_err0, b_err1, b_run, b_stall;
    logic [31:0] b_z0, b_z1, b_dx, b_dy, b_dz;
    logic [7:0]  a_steps = 8'd0;
    logic [7:0]  b_steps = 8'd0;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_done = 0;
    int viol = 0;
    int ack_cyc = 0;
    int gp_m = 0;
    int err_last = 0;
    int b_n0 = 0;
    int b_n1 = 0;
    int order_q[$];
    int lat_q[$];

    fp_div_arbiter #(.RR(1'b1), .TMO(TMO)) u_rr (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .ack0(a_ack0), .ack1(a_ack1), .done0(a_done0), .done1(a_done1),
        .err0(a_err0), .err1(a_err1), .z0(a_z0), .z1(a_z1),
        .run(a_run), .dx(a_dx), .dy(a_dy), .stall(a_stall), .dz(a_dz)
    );

    fp_div_arbiter #(.RR(1'b0), .TMO(TMO)) u_fp (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .ack0(b_ack0), .ack1(b_ack1), .done0(b_done0), .done1(b_done1),
        .err0(b_err0), .err1(b_err1), .z0(b_z0), .z1(b_z1),
        .run(b_run), .dx(b_dx), .dy(b_dy), .stall(b_stall), .dz(b_dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed quotients for the operand pairs this bench uses.
    function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] key;
        key = {a, b};
        case (key)
            64'h40C00000_40000000: quot = 32'h40400000;
            64'h41200000_40A00000: quot = 32'h40000000;
            64'h3F800000_00000000: quot = 32'h7F800000;
            64'h41000000_40000000: quot = 32'h40800000;
            default:               quot = 32'h00000000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!a_run) a_steps <= 8'd0;
        else if (a_steps != 8'hFF) a_steps <= a_steps + 8'd1;
        if (!b_run) b_steps <= 8'd0;
        else if (b_steps != 8'hFF) b_steps <= b_steps + 8'd1;
    end

    assign a_stall = stuck | (a_steps < 8'd25);
    assign b_stall = stuck | (b_steps < 8'd25);
    assign a_dz    = quot(a_dx, a_dy);
    assign b_dz    = quot(b_dx, b_dy);

    // Event log and protocol watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_ack0 && a_ack1) viol++;
        if (a_ack0 || a_ack1) begin
            gp_m    = a_ack1 ? 1 : 0;
            ack_cyc = cyc;
            order_q.push_back(gp_m);
        end
        if (a_done0 || a_done1) begin
            if ((a_done0 && a_done1) || (a_done1 ? 1 : 0) != gp_m) viol++;
            lat_q.push_back(cyc - ack_cyc);
            err_last = a_done1 ? int'(a_err1) : int'(a_err0);
            n_done++;
        end
        if ((a_err0 && !a_done0) || (a_err1 && !a_done1)) viol++;
        if (b_ack0) b_n0++;
        if (b_ack1) b_n1++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dones(input int target, input int lim);
        for (int i = 0; i < lim && n_done < target; i++) tick();
        if (n_done < target) check("wait_done", 32'd0, 32'd1);
    endtask

    task automatic one_shot(input int p);
        if (p == 0) req0 = 1'b1;
        else        req1 = 1'b1;
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        int base;
        int nd;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; stuck = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        tick();
        tick();

        // Reset state
        check("rst_run",   32'(a_run),   32'd0);
        check("rst_ack",   32'({a_ack0, a_ack1}), 32'd0);
        check("rst_done",  32'({a_done0, a_done1, a_err0, a_err1}), 32'd0);
        check("rst_z0",    a_z0, 32'd0);
        check("rst_z1",    a_z1, 32'd0);
        check("rst_dx",    a_dx, 32'd0);
        check("rst_dy",    a_dy, 32'd0);
        rst = 1'b0;

        // Port 0 alone: 6.0 / 2.0
        x0 = 32'h40C00000; y0 = 32'h40000000;
        one_shot(0);
        check("p0_dx", a_dx, 32'h40C00000);
        x0 = 32'h12345678;
        wait_dones(1, 60);
        check("p0_lat",  32'(lat_q[$]), 32'd27);
        check("p0_z0",   a_z0, 32'h40400000);
        check("p0_z1",   a_z1, 32'd0);
        check("p0_err",  32'(err_last), 32'd0);

        // Both ports held, round-robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        x0 = 32'h40C00000; y0 = 32'h40000000;
        x1 = 32'h41200000; y1 = 32'h40A00000;
        base = order_q.size();
        nd = n_done;
        b_n0 = 0; b_n1 = 0;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 200 && order_q.size() < base + 3; i++) tick();
        req0 = 1'b0; req1 = 1'b0;
        wait_dones(nd + 3, 100);
        if (order_q.size() >= base + 3 && lat_q.size() >= 3) begin
            check("rr_g0", 32'(order_q[base]),     32'd0);
            check("rr_g1", 32'(order_q[base + 1]), 32'd1);
            check("rr_g2", 32'(order_q[base + 2]), 32'd0);
            check("rr_l0", 32'(lat_q[lat_q.size() - 3]), 32'd27);
            check("rr_l1", 32'(lat_q[lat_q.size() - 2]), 32'd27);
            check("rr_l2", 32'(lat_q[lat_q.size() - 1]), 32'd27);
        end else begin
            check("rr_count", 32'(order_q.size() - base), 32'd3);
        end
        check("rr_z1", a_z1, 32'h40000000);
        check("rr_z0", a_z0, 32'h40400000);
        check("fp_ack0", 32'(b_n0), 32'd3);
        check("fp_ack1", 32'(b_n1), 32'd0);

        // Divide by zero on port 1
        x1 = 32'h3F800000; y1 = 32'h00000000;
        nd = n_done;
        one_shot(1);
        wait_dones(nd + 1, 60);
        check("dz_lat", 32'(lat_q[$]), 32'd27);
        check("dz_z1",  a_z1, 32'h7F800000);
        check("dz_err", 32'(err_last), 32'd0);
        check("dz_z0",  a_z0, 32'h40400000);

        // Divider stuck busy: watchdog abort
        stuck = 1'b1;
        x0 = 32'h40C00000; y0 = 32'h40000000;
        nd = n_done;
        one_shot(0);
        wait_dones(nd + 1, 80);
        check("to_lat", 32'(lat_q[$]), 32'(TMO + 2));
        check("to_err", 32'(err_last), 32'd1);
        check("to_z0",  a_z0, 32'd0);
        check("to_run", 32'(a_run), 32'd0);
        stuck = 1'b0;

        // Reset ten cycles into an operation
        tick();
        one_shot(0);
        repeat (9) tick();
        nd = n_done;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ra_run", 32'(a_run), 32'd0);
        repeat (40) tick();
        check("ra_nodone", 32'(n_done), 32'(nd));
        x0 = 32'h41000000; y0 = 32'h40000000;
        one_shot(0);
        wait_dones(nd + 1, 60);
        check("ra_lat", 32'(lat_q[$]), 32'd27);
        check("ra_z0",  a_z0, 32'h40800000);

        tick();
        check("protocol", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_div_arbiter.md
FP_DIV_ARBITER -- requirements
Module: fp_div_arbiter

Interface
REQ-001 Parameter RR, default 1, arbitration mode: 1 = round-robin between ports, 0 = fixed priority with port 0 winning.
REQ-002 Parameter TMO, default 31, watchdog limit in RUN-state cycles before an operation is aborted.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req0, req1  in  1 each  level request from port 0 / port 1; operands are valid whenever req is high.
REQ-006 x0, y0, x1, y1  in  32 each  dividend / divisor, IEEE single format, per port.
REQ-007 ack0, ack1  out  1 each  one-cycle pulse: this port's operands are captured this cycle.
REQ-008 done0, done1  out  1 each  one-cycle pulse: this port's z is valid.
REQ-009 err0, err1  out  1 each  one-cycle pulse, coincident with done: the operation timed out.
REQ-010 z0, z1  out  32 each  per-port quotient register, held until that port's next completion.
REQ-011 run  out  1  divider run strobe.
REQ-012 dx, dy  out  32 each  registered operands to the divider.
REQ-013 stall  in  1  divider busy; low while run is high means the result is valid.
REQ-014 dz  in  32  divider quotient.

Function
REQ-015 States: IDLE, RUN, DONE; run SHALL be 1 only in RUN.
REQ-016 IDLE with no req high: remain in IDLE with all pulses low.
REQ-017 IDLE with one req high: grant that port, load dx/dy from its x/y, pulse its ack, and go to RUN.
REQ-018 IDLE with both req high, RR=1: grant the port that is not the last-granted pointer lp.
REQ-019 IDLE with both req high, RR=0: grant port 0.
REQ-020 lp SHALL update to the granted port on every grant.
REQ-021 dx/dy SHALL NOT change outside an IDLE grant cycle; x/y changes during RUN have no effect.
REQ-022 RUN: count cycles in a 5-bit counter cnt that is cleared on entry.
REQ-023 RUN, first cycle with stall=0: capture dz into z of the granted port and go to DONE.
REQ-024 RUN, cnt reaching TMO with stall still 1: write 0 to z of the granted port, set a timeout flag, and go to DONE.
REQ-025 DONE lasts exactly one cycle: pulse done of the granted port, pulse err if the timeout flag is set, then go to IDLE.
REQ-026 run is 0 in DONE and IDLE, so there is at least two cycles of run low between operations and the divider step counter restarts from 0.
REQ-027 Latency with a 25-step divider: grant at cycle t, run high t+1..t+26, capture at t+26, done at t+27, and the next grant is possible at t+28.
REQ-028 A req still high in the cycle after done is a new request; back-to-back operations are allowed.
REQ-029 A req dropped while that port is in RUN does not cancel the operation; done still pulses.
REQ-030 ack, done and err of the non-granted port SHALL stay 0 throughout.
REQ-031 A port that is not granted keeps its z unchanged.

Reset
REQ-032 With rst high at an edge, the next state SHALL be IDLE, run=0, all ack/done/err=0, z0=z1=0, dx=dy=0, cnt=0, lp=1.
REQ-033 Reset during RUN SHALL abandon the operation with no done, and run SHALL be low the next cycle.
REQ-034 With rst held low thereafter, the first grant after reset SHALL be legal from the first cycle.

Verification
REQ-035 Port 0 alone, x0=0x40C00000 (6.0), y0=0x40000000 (2.0): ack0 at t, done0 at t+27, z0=0x40400000, z1 unchanged.
REQ-036 Both ports request at once, RR=1, held for three operations: grant order is 0, 1, 0; each done is 27 cycles after its ack; z1 equals x1/y1.
REQ-037 RR=0, both ports held high: port 0 is granted repeatedly and port 1 is never acked.
REQ-038 Stub the divider with stall stuck at 1: done0 and err0 pulse together TMO+2 cycles after ack0, z0=0, then return to IDLE.
REQ-039 Assert rst at t+10 of an operation: run=0 at t+11, no done, and a fresh request gives a correct result 27 cycles after its ack.
REQ-040 y1=0 (divisor 0x00000000), x1=0x3F800000: z1=0x7F800000 and err1=0.
